i2s_tx_serializer: RTL and testbench

- Downstream stage of the BRAM audio fetch/DMA logic. Accepts stereo PCM sample pairs over a valid/ready handshake and drives the codec's I2S playback pins (bclk, pblrc, pbdat) in standard Philips I2S format.
- Runs entirely on the fabric clock. bclk and lrclk are generated internally by division, so no second clock domain exists.
- A one-pair holding register decouples the upstream fetcher from frame timing.

---
 rtl/i2s_pkg.sv | 21 ++
 rtl/i2s_tx_serializer_if.sv | 17 +
 rtl/i2s_clkgen.sv | 62 ++++++
 rtl/i2s_tx_serializer.sv | 128 ++++++++++++
 tb/tb_i2s_tx_serializer.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2s_pkg.sv
// i2s_pkg: shared types and default geometry for the I2S playback serializer.
// The default sample/slot widths match the 24-bit-in-32-bit-slot codec setup.
package i2s_pkg;

   localparam int BCLK_DIV_DEF = 16;
   localparam int SLOT_W_DEF   = 32;
   localparam int SAMPLE_W_DEF = 24;

   typedef logic signed [SAMPLE_W_DEF-1:0] sample_t;

   typedef struct packed {
      sample_t left;
      sample_t right;
   } stereo_t;

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/i2s_tx_serializer_if.sv
// i2s_tx_serializer_if: valid/ready sample-pair stream feeding the serializer.
// master = upstream fetcher, slave = serializer holding register.
interface i2s_tx_serializer_if
   import i2s_pkg::*;
#(
   parameter int SAMPLE_W = SAMPLE_W_DEF
);

   logic                       s_valid;
   logic                       s_ready;
   logic signed [SAMPLE_W-1:0] s_left;
   logic signed [SAMPLE_W-1:0] s_right;

   modport master (output s_valid, output s_left, output s_right, input s_ready);
   modport slave  (input s_valid, input s_left, input s_right, output s_ready);

endinterface

// File: rtl/i2s_clkgen.sv
// i2s_clkgen: divides the fabric clock into bclk and walks the frame bit
// counter / word select. fall_evt_o marks the clk in which bclk goes 1->0;
// bit_cnt_o is the count that takes effect at that edge, so the parent can
// register data for the new bit position in the same clk.
module i2s_clkgen
   import i2s_pkg::*;
#(
   parameter  int BCLK_DIV = BCLK_DIV_DEF,
   parameter  int SLOT_W   = SLOT_W_DEF,
   localparam int DIV_W    = cnt_w(BCLK_DIV),
   localparam int BIT_W    = cnt_w(2*SLOT_W)
) (
   input  logic             clk,
   input  logic             rstn,
   output logic             bclk_o,
   output logic             lrclk_o,
   output logic             fall_evt_o,
   output logic [BIT_W-1:0] bit_cnt_o
);

   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic             bclk_q, bclk_d;
   logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic             lrclk_q, lrclk_d;
   logic             div_tc;
   logic             fall_evt;

   // Next-state: divider, bclk toggle, and bit/word-select advance on bclk fall.
   always_comb begin
      div_tc    = (div_cnt_q == DIV_W'(BCLK_DIV-1));
      div_cnt_d = div_tc ? '0 : div_cnt_q + 1'b1;
      bclk_d    = div_tc ? ~bclk_q : bclk_q;
      fall_evt  = div_tc && bclk_q;
      bit_cnt_d = bit_cnt_q;
      lrclk_d   = lrclk_q;
      if (fall_evt) begin
         bit_cnt_d = (bit_cnt_q == BIT_W'(2*SLOT_W-1)) ? '0 : bit_cnt_q + 1'b1;
         lrclk_d   = (bit_cnt_d >= BIT_W'(SLOT_W));
      end
   end

   // Timing state; reset parks the counter on the last bit so the first fall loads a frame.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         div_cnt_q <= '0;
         bclk_q    <= 1'b0;
         bit_cnt_q <= BIT_W'(2*SLOT_W-1);
         lrclk_q   <= 1'b1;
      end else begin
         div_cnt_q <= div_cnt_d;
         bclk_q    <= bclk_d;
         bit_cnt_q <= bit_cnt_d;
         lrclk_q   <= lrclk_d;
      end
   end

   assign bclk_o     = bclk_q;
   assign lrclk_o    = lrclk_q;
   assign fall_evt_o = fall_evt;
   assign bit_cnt_o  = bit_cnt_d;

endmodule

// File: rtl/i2s_tx_serializer.sv
// i2s_tx_serializer: Philips I2S playback serializer with a one-pair holding
// register. All I2S outputs change only in the clk of a bclk falling event.
// Optional build macro I2S_TX_HOLD_LAST_EN: when defined, an underrun frame
// replays the previous pair instead of sending silence.
module i2s_tx_serializer
   import i2s_pkg::*;
#(
   parameter int BCLK_DIV = BCLK_DIV_DEF,
   parameter int SLOT_W   = SLOT_W_DEF,
   parameter int SAMPLE_W = SAMPLE_W_DEF
) (
   input  logic                 clk,
   input  logic                 rstn,
   i2s_tx_serializer_if.slave   s_if,
   output logic                 i2s_bclk,
   output logic                 i2s_lrclk,
   output logic                 i2s_sdata,
   output logic                 underrun,
   output logic                 frame_start
);

   localparam int BIT_W = cnt_w(2*SLOT_W);

   typedef struct packed {
      logic signed [SAMPLE_W-1:0] left;
      logic signed [SAMPLE_W-1:0] right;
   } pair_t;

   pair_t                      hold_q, hold_d;
   pair_t                      frame_q, frame_d;
   logic                       hold_valid_q, hold_valid_d;
   logic                       sdata_q, sdata_d;
   logic                       underrun_q, underrun_d;
   logic                       frame_start_q, frame_start_d;

   logic                       fall_evt;
   logic [BIT_W-1:0]           bit_cnt;
   logic                       accept;
   logic                       load;
   logic                       in_right;
   logic [BIT_W-1:0]           pos;
   logic signed [SAMPLE_W-1:0] slot_sample;
   logic                       slot_bit;

   i2s_clkgen #(
      .BCLK_DIV (BCLK_DIV),
      .SLOT_W   (SLOT_W)
   ) u_clkgen (
      .clk        (clk),
      .rstn       (rstn),
      .bclk_o     (i2s_bclk),
      .lrclk_o    (i2s_lrclk),
      .fall_evt_o (fall_evt),
      .bit_cnt_o  (bit_cnt)
   );

   assign s_if.s_ready = !hold_valid_q;

   // Bit selection for the new position: MSB sits one bclk after the slot start.
   always_comb begin
      in_right    = (bit_cnt >= BIT_W'(SLOT_W));
      pos         = in_right ? bit_cnt - BIT_W'(SLOT_W) : bit_cnt;
      slot_sample = in_right ? frame_q.right : frame_q.left;
      slot_bit    = 1'b0;
      for (int k = 0; k < SAMPLE_W; k++) begin
         if (pos == BIT_W'(SAMPLE_W-k)) slot_bit = slot_sample[k];
      end
   end

   // Handshake, frame load and serial data next-state.
   always_comb begin
      accept        = s_if.s_valid && !hold_valid_q;
      load          = fall_evt && (bit_cnt == '0);
      hold_d        = hold_q;
      hold_valid_d  = hold_valid_q;
      frame_d       = frame_q;
      sdata_d       = sdata_q;
      underrun_d    = 1'b0;
      frame_start_d = 1'b0;
      if (accept) begin
         hold_d.left  = s_if.s_left;
         hold_d.right = s_if.s_right;
         hold_valid_d = 1'b1;
      end
      if (fall_evt) sdata_d = slot_bit;
      if (load) begin
         frame_start_d = 1'b1;
         if (hold_valid_q) begin
            frame_d      = hold_q;
            hold_valid_d = 1'b0;
         end else begin
            underrun_d = 1'b1;
`ifdef I2S_TX_HOLD_LAST_EN
            frame_d    = frame_q;
`else
            frame_d    = '0;
`endif
         end
      end
   end

   // Control, frame register and output flops; reset discards any held pair.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         hold_valid_q  <= 1'b0;
         frame_q       <= '0;
         sdata_q       <= 1'b0;
         underrun_q    <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         hold_valid_q  <= hold_valid_d;
         frame_q       <= frame_d;
         sdata_q       <= sdata_d;
         underrun_q    <= underrun_d;
         frame_start_q <= frame_start_d;
      end
   end

   // Holding register payload; only meaningful while hold_valid_q is set.
   always_ff @(posedge clk) begin
      hold_q <= hold_d;
   end

   assign i2s_sdata   = sdata_q;
   assign underrun    = underrun_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// tb_i2s_tx_serializer: directed + randomized bench for i2s_tx_serializer.
// Frames are captured on bclk rising edges and compared with a frame image
// built from the accepted pairs: {0, L, 7'b0, 0, R, 7'b0}, sent MSB first.
module tb_i2s_tx_serializer;
   import i2s_pkg::*;

   localparam int BCLK_DIV   = 2;
   localparam int SLOT_W     = 32;
   localparam int SAMPLE_W   = 24;
   localparam int FRAME_CLKS = 2 * SLOT_W * 2 * BCLK_DIV;
   localparam logic [63:0] LR_EXP = 64'h00000000_FFFFFFFF;

   logic clk = 1'b0;
   logic rstn;
   logic bclk, lrclk, sdata, underrun, frame_start;
   int unsigned cyc = 0;

   i2s_tx_serializer_if #(.SAMPLE_W(SAMPLE_W)) sif();

   i2s_tx_serializer #(
      .BCLK_DIV (BCLK_DIV),
      .SLOT_W   (SLOT_W),
      .SAMPLE_W (SAMPLE_W)
   ) dut (
      .clk         (clk),
      .rstn        (rstn),
      .s_if        (sif),
      .i2s_bclk    (bclk),
      .i2s_lrclk   (lrclk),
      .i2s_sdata   (sdata),
      .underrun    (underrun),
      .frame_start (frame_start)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [63:0] word;
      logic [63:0] lr;
      logic        urun;
      int unsigned start;
   } frame_t;

   frame_t      frames_q[$];
   stereo_t     acc_q[$];
   logic [63:0] last_w = '0;
   int          checks = 0;
   int          errors = 0;
   int          bclk_bad = 0;
   int          chg_bad = 0;

   function automatic logic [63:0] fw(input stereo_t p);
      return {1'b0, p.left, 7'b0, 1'b0, p.right, 7'b0};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Waits (bounded) for a frame_start pulse, sampled on the falling clk edge.
   task automatic wait_fs(input string tag);
      int t = 0;
      @(negedge clk);
      while (frame_start !== 1'b1 && t < 2 * FRAME_CLKS) begin
         @(negedge clk);
         t++;
      end
      checks++;
      assert (frame_start === 1'b1) else begin
         errors++;
         $error("FAIL %s_timeout: observed frame_start=%b expected=1", tag, frame_start);
      end
   endtask

   // Offers one pair once s_ready is seen; returns one clk after acceptance.
   task automatic push(input string tag, input stereo_t p);
      int t = 0;
      while (sif.s_ready !== 1'b1 && t < 4 * FRAME_CLKS) begin
         @(negedge clk);
         t++;
      end
      checks++;
      assert (sif.s_ready === 1'b1) else begin
         errors++;
         $error("FAIL %s_push_timeout: observed s_ready=%b expected=1", tag, sif.s_ready);
      end
      if (sif.s_ready === 1'b1) begin
         sif.s_valid = 1'b1;
         sif.s_left  = p.left;
         sif.s_right = p.right;
         acc_q.push_back(p);
         @(negedge clk);
         sif.s_valid = 1'b0;
         sif.s_left  = $urandom;
         sif.s_right = $urandom;
      end
   endtask

   // Pops the next captured frame and scores it against the reference model.
   task automatic consume(input string tag, output logic urun, output int unsigned st);
      int          t = 0;
      frame_t      f;
      logic [63:0] exp;
      urun = 1'b0;
      st   = 0;
      while (frames_q.size() == 0 && t < 3 * FRAME_CLKS) begin
         @(negedge clk);
         t++;
      end
      checks++;
      assert (frames_q.size() != 0) else begin
         errors++;
         $error("FAIL %s_frame_timeout: observed frames=%0d expected>0", tag, frames_q.size());
      end
      if (frames_q.size() != 0) begin
         f = frames_q.pop_front();
         if (f.urun === 1'b1) begin
`ifdef I2S_TX_HOLD_LAST_EN
            exp = last_w;
`else
            exp = '0;
`endif
         end else begin
            checks++;
            assert (acc_q.size() != 0) else begin
               errors++;
               $error("FAIL %s_extra_frame: observed pending=%0d expected>0", tag, acc_q.size());
            end
            exp = (acc_q.size() != 0) ? fw(acc_q.pop_front()) : '0;
            last_w = exp;
         end
         check({tag, "_data"}, f.word, exp);
         check({tag, "_lrclk"}, f.lr, LR_EXP);
         urun = f.urun;
         st   = f.start;
      end
   endtask

   // Monitor: bclk phase lengths, change-only-on-fall rule, frame capture.
   initial begin : mon
      logic   pb, plr, psd;
      bit     pok, rv, inf;
      int     run, cnt;
      frame_t cur;
      pb = 1'b0; plr = 1'b0; psd = 1'b0;
      pok = 1'b0; rv = 1'b0; inf = 1'b0; run = 0; cnt = 0;
      cur.word = '0; cur.lr = '0; cur.urun = 1'b0; cur.start = 0;
      forever begin
         @(negedge clk);
         if (rstn !== 1'b1) begin
            pok = 1'b0; rv = 1'b0; inf = 1'b0; cnt = 0; pb = 1'b0;
         end else begin
            if (pok) begin
               if (bclk === pb) run++;
               else begin
                  if (rv && run != BCLK_DIV) bclk_bad++;
                  rv  = 1'b1;
                  run = 1;
               end
               if (!(pb && !bclk) && (lrclk !== plr || sdata !== psd)) chg_bad++;
            end else begin
               run = 1;
            end
            if (frame_start === 1'b1) begin
               inf = 1'b1; cnt = 0;
               cur.urun = underrun; cur.start = cyc; cur.word = '0; cur.lr = '0;
            end
            if (inf && pok && !pb && bclk) begin
               cur.word = {cur.word[62:0], sdata};
               cur.lr   = {cur.lr[62:0], lrclk};
               cnt++;
               if (cnt == 2 * SLOT_W) begin
                  frames_q.push_back(cur);
                  inf = 1'b0;
               end
            end
            pb = bclk; plr = lrclk; psd = sdata; pok = 1'b1;
         end
      end
   end

   initial begin : main
      logic        u;
      int unsigned st1, st2, st;
      stereo_t     a, b, pr;
      logic [23:0] v;
      int unsigned base, n;
      int unsigned acc_cyc[$];

      sif.s_valid = 1'b0;
      sif.s_left  = '0;
      sif.s_right = '0;
      rstn = 1'b1;
      #1 rstn = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_bclk", bclk, 1'b0);
      check("rst_lrclk", lrclk, 1'b1);
      check("rst_sdata", sdata, 1'b0);
      check("rst_ready", sif.s_ready, 1'b1);
      check("rst_underrun", underrun, 1'b0);
      check("rst_frame_start", frame_start, 1'b0);

      // Pair pushed before the first load, then silence.
      rstn = 1'b1;
      a.left = 24'hABCDEF; a.right = 24'h123456;
      push("p1", a);
      check("p1_ready_low_held", sif.s_ready, 1'b0);
      wait_fs("p1_load");
      check("p1_ready_after_load", sif.s_ready, 1'b1);
      repeat (2 * BCLK_DIV - 1) @(negedge clk);
      check("p1_slot_pos0", sdata, 1'b0);
      @(negedge clk);
      check("p1_left_msb_latency", sdata, a.left[SAMPLE_W-1]);
      consume("p1_f1", u, st1);
      check("p1_f1_urun", u, 1'b0);
      consume("p1_f2", u, st2);
      check("p1_f2_urun", u, 1'b1);
      check("p1_frame_period", st2 - st1, FRAME_CLKS);
      for (int i = 0; i < 2; i++) begin
         consume("p2_idle", u, st);
         check("p2_idle_urun", u, 1'b1);
      end

      // Streaming: s_valid held high with an incrementing pattern.
      wait_fs("p3_sync");
      base = $urandom;
      n = 0;
      sif.s_valid = 1'b1;
      for (int c = 0; c < 20 * FRAME_CLKS && n < 8; c++) begin
         v = base[23:0] + 24'(n);
         pr.left = v; pr.right = ~v;
         sif.s_left = pr.left; sif.s_right = pr.right;
         if (sif.s_ready === 1'b1) begin
            acc_q.push_back(pr);
            acc_cyc.push_back(cyc);
            n++;
         end
         @(negedge clk);
      end
      sif.s_valid = 1'b0;
      check("p3_accepts", 64'(n), 64'd8);
      for (int i = 1; i < acc_cyc.size(); i++)
         check("p3_accept_spacing", 64'(acc_cyc[i] - acc_cyc[i-1]), 64'(FRAME_CLKS));
      consume("p3_pre", u, st);
      check("p3_pre_urun", u, 1'b1);
      for (int i = 0; i < 8; i++) begin
         consume("p3_stream", u, st);
         check("p3_stream_urun", u, 1'b0);
      end
      check("p3_drained", 64'(acc_q.size()), 64'd0);

      // Reset in the middle of the right slot with a pair held.
      wait_fs("p4_sync");
      b.left = 24'($urandom); b.right = 24'($urandom);
      push("p4", b);
      repeat (150) @(negedge clk);
      check("p4_mid_right_lrclk", lrclk, 1'b1);
      check("p4_pair_held", sif.s_ready, 1'b0);
      #2 rstn = 1'b0;
      #1;
      check("p4_rst_bclk", bclk, 1'b0);
      check("p4_rst_lrclk", lrclk, 1'b1);
      check("p4_rst_sdata", sdata, 1'b0);
      check("p4_rst_ready", sif.s_ready, 1'b1);
      check("p4_rst_underrun", underrun, 1'b0);
      check("p4_rst_frame_start", frame_start, 1'b0);
      repeat (3) @(negedge clk);
      frames_q.delete();
      acc_q.delete();
      last_w = '0;
      rstn = 1'b1;
      consume("p4_after", u, st);
      check("p4_after_urun", u, 1'b1);

      // Extreme values, then random pairs.
      pr.left = 24'h800000; pr.right = 24'h7FFFFF;
      push("p5_ext", pr);
      for (int i = 0; i < 6; i++) begin
         pr.left = 24'($urandom); pr.right = 24'($urandom);
         push("p5_rand", pr);
      end
      for (int i = 0; i < 12 && acc_q.size() != 0; i++) consume("p5", u, st);
      check("p5_drained", 64'(acc_q.size()), 64'd0);

      check("bclk_phase_len", 64'(bclk_bad), 64'd0);
      check("change_only_on_fall", 64'(chg_bad), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
